// File: rtl/uart_echo_responder_if.sv
// Receiver-to-responder and responder-to-transmitter handshake bundle.
// The slave modport is the echo responder's view; master is the UART side.
interface uart_echo_responder_if;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;
  logic       Tx_BUSY;
  logic [7:0] Tx_DATA;
  logic       Tx_WR;

  modport slave (
    input  Rx_DATA,
    input  Rx_VALID,
    input  Rx_PERROR,
    input  Rx_FERROR,
    input  Tx_BUSY,
    output Tx_DATA,
    output Tx_WR
  );

  modport master (
    output Rx_DATA,
    output Rx_VALID,
    output Rx_PERROR,
    output Rx_FERROR,
    output Tx_BUSY,
    input  Tx_DATA,
    input  Tx_WR
  );
endinterface

// File: rtl/uart_echo_responder.sv
// Echoes every byte validated by the UART receiver back to the transmitter
// through a small circular FIFO, with error/overflow policy and counters.
module uart_echo_responder #(
  parameter int         FIFO_DEPTH = 4,
  parameter bit         ERR_REPLY  = 1'b0,
  parameter logic [7:0] ERR_BYTE   = 8'h3F
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  uart_echo_responder_if.slave          uif,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic            valid_q_reg;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg, count_next;
  logic [7:0]      drop_count_reg, drop_count_next;
  logic            overflow_reg;
  logic [7:0]      tx_data_reg;
  logic [7:0]      mem [FIFO_DEPTH];

  logic            rise;
  logic            has_err;
  logic            push_req;
  logic            push_ok;
  logic            err_drop;
  logic            ovf_drop;
  logic [7:0]      push_byte;
  logic            full;
  logic            empty;
  logic            load;
  logic            pop;

  // Edge detect so a level-style Rx_VALID yields exactly one capture.
  assign rise      = uif.Rx_VALID & ~valid_q_reg;
  assign has_err   = uif.Rx_PERROR | uif.Rx_FERROR;
  assign push_req  = rise & en & (~has_err | ERR_REPLY);
  assign err_drop  = rise & en & has_err & ~ERR_REPLY;
  assign push_byte = has_err ? ERR_BYTE : uif.Rx_DATA;

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req & (~full | pop);
  assign ovf_drop = push_req & full & ~pop;

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    pop        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (en && !empty && !uif.Tx_BUSY) begin
          load       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (uif.Tx_BUSY) begin
          pop        = 1'b1;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!uif.Tx_BUSY) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop) begin
      count_next = count_reg + ONE_COUNT;
    end else if (pop && !push_ok) begin
      count_next = count_reg - ONE_COUNT;
    end
  end

  always_comb begin
    drop_count_next = drop_count_reg;
    if ((err_drop || ovf_drop) && drop_count_reg != 8'hFF) begin
      drop_count_next = drop_count_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      valid_q_reg    <= 1'b1;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      drop_count_reg <= 8'd0;
      overflow_reg   <= 1'b0;
      tx_data_reg    <= 8'd0;
    end else begin
      state_reg      <= state_next;
      valid_q_reg    <= uif.Rx_VALID;
      count_reg      <= count_next;
      drop_count_reg <= drop_count_next;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (ovf_drop) begin
        overflow_reg <= 1'b1;
      end
      // Head byte is latched once per frame and held until the next load.
      if (load) begin
        tx_data_reg <= mem[rd_ptr_reg];
      end
    end
  end

  assign uif.Tx_DATA = tx_data_reg;
  assign uif.Tx_WR   = (state_reg == ISSUE);
  assign fifo_count  = count_reg;
  assign drop_count  = drop_count_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Directed bench for uart_echo_responder: a table of per-cycle vectors plus
// hand-written sequences driven against a simple transmitter busy model.
module tb_uart_echo_responder;

  typedef struct {
    int rst;
    int en;
    int valid;
    int data;
    int perr;
    int busy;
    int e_count;
    int e_wr;
    int e_data;
    int e_drop;
    int e_ovf;
  } vec_t;

  localparam int NVEC = 28;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_perr = 1'b0;
  logic       rx_ferr = 1'b0;
  logic       man_busy = 1'b0;
  logic       model_on = 1'b0;
  logic       mbusy0, mbusy1;
  int         mcnt0, mcnt1;
  int         busy_len = 3;
  logic [7:0] frames0 [$];
  logic [7:0] frames1 [$];

  logic [2:0] count0, count1;
  logic [7:0] drop0, drop1;
  logic       ovf0, ovf1;

  vec_t tbl [NVEC];
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  uart_echo_responder_if if0 ();
  uart_echo_responder_if if1 ();

  assign if0.Rx_DATA   = rx_data;
  assign if0.Rx_VALID  = rx_valid;
  assign if0.Rx_PERROR = rx_perr;
  assign if0.Rx_FERROR = rx_ferr;
  assign if0.Tx_BUSY   = model_on ? mbusy0 : man_busy;
  assign if1.Rx_DATA   = rx_data;
  assign if1.Rx_VALID  = rx_valid;
  assign if1.Rx_PERROR = rx_perr;
  assign if1.Rx_FERROR = rx_ferr;
  assign if1.Tx_BUSY   = model_on ? mbusy1 : man_busy;

  uart_echo_responder #(.FIFO_DEPTH(4), .ERR_REPLY(1'b0), .ERR_BYTE(8'h3F)) dut0 (
    .clk(clk), .reset(reset), .en(en), .uif(if0),
    .fifo_count(count0), .drop_count(drop0), .overflow(ovf0)
  );

  uart_echo_responder #(.FIFO_DEPTH(4), .ERR_REPLY(1'b1), .ERR_BYTE(8'h3F)) dut1 (
    .clk(clk), .reset(reset), .en(en), .uif(if1),
    .fifo_count(count1), .drop_count(drop1), .overflow(ovf1)
  );

  // Transmitter model: raises busy the cycle after it sees Tx_WR, for busy_len cycles.
  always @(posedge clk) begin
    if (!model_on || reset) begin
      mbusy0 <= 1'b0;
      mcnt0  <= 0;
    end else if (mbusy0) begin
      if (mcnt0 <= 1) mbusy0 <= 1'b0;
      mcnt0 <= mcnt0 - 1;
    end else if (if0.Tx_WR) begin
      mbusy0 <= 1'b1;
      mcnt0  <= busy_len;
      frames0.push_back(if0.Tx_DATA);
      $display("dut0 frame %02h", if0.Tx_DATA);
    end
  end

  always @(posedge clk) begin
    if (!model_on || reset) begin
      mbusy1 <= 1'b0;
      mcnt1  <= 0;
    end else if (mbusy1) begin
      if (mcnt1 <= 1) mbusy1 <= 1'b0;
      mcnt1 <= mcnt1 - 1;
    end else if (if1.Tx_WR) begin
      mbusy1 <= 1'b1;
      mcnt1  <= busy_len;
      frames1.push_back(if1.Tx_DATA);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] f0(input int i);
    return (i < frames0.size()) ? 32'(frames0[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] f1(input int i);
    return (i < frames1.size()) ? 32'(frames1[i]) : 32'hDEAD;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rx_valid = 1'b0; rx_perr = 1'b0; rx_ferr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] d, input logic pe, input logic fe);
    rx_data = d; rx_perr = pe; rx_ferr = fe; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_perr = 1'b0; rx_ferr = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      reset    = (tbl[i].rst != 0);
      en       = (tbl[i].en != 0);
      rx_valid = (tbl[i].valid != 0);
      rx_data  = 8'(tbl[i].data);
      rx_perr  = (tbl[i].perr != 0);
      rx_ferr  = 1'b0;
      man_busy = (tbl[i].busy != 0);
      @(posedge clk);
      #1;
      $display("vec %0d: rst=%0d v=%0d d=%02h busy=%0d -> count=%0d wr=%0b tx=%02h drop=%0d ovf=%0b",
               i, tbl[i].rst, tbl[i].valid, tbl[i].data, tbl[i].busy,
               count0, if0.Tx_WR, if0.Tx_DATA, drop0, ovf0);
      chk($sformatf("vec%0d_count", i), 32'(count0), tbl[i].e_count);
      chk($sformatf("vec%0d_wr", i), 32'(if0.Tx_WR), tbl[i].e_wr);
      chk($sformatf("vec%0d_txdata", i), 32'(if0.Tx_DATA), tbl[i].e_data);
      chk($sformatf("vec%0d_drop", i), 32'(drop0), tbl[i].e_drop);
      chk($sformatf("vec%0d_ovf", i), 32'(ovf0), tbl[i].e_ovf);
    end
  endtask

  initial begin
    int n0, n1, wr_seen, cnt_seen, ok;
    //          rst en v  data  pe busy cnt wr data  drop ovf
    // Fill six bytes while the transmitter is busy, then release it.
    tbl[0]  = '{1, 1, 0, 'h00, 0, 1, 0, 0, 'h00, 0, 0};
    tbl[1]  = '{0, 1, 0, 'h00, 0, 1, 0, 0, 'h00, 0, 0};
    tbl[2]  = '{0, 1, 1, 'h01, 0, 1, 1, 0, 'h00, 0, 0};
    tbl[3]  = '{0, 1, 0, 'h00, 0, 1, 1, 0, 'h00, 0, 0};
    tbl[4]  = '{0, 1, 1, 'h02, 0, 1, 2, 0, 'h00, 0, 0};
    tbl[5]  = '{0, 1, 0, 'h00, 0, 1, 2, 0, 'h00, 0, 0};
    tbl[6]  = '{0, 1, 1, 'h03, 0, 1, 3, 0, 'h00, 0, 0};
    tbl[7]  = '{0, 1, 0, 'h00, 0, 1, 3, 0, 'h00, 0, 0};
    tbl[8]  = '{0, 1, 1, 'h04, 0, 1, 4, 0, 'h00, 0, 0};
    tbl[9]  = '{0, 1, 0, 'h00, 0, 1, 4, 0, 'h00, 0, 0};
    tbl[10] = '{0, 1, 1, 'h05, 0, 1, 4, 0, 'h00, 1, 1};
    tbl[11] = '{0, 1, 0, 'h00, 0, 1, 4, 0, 'h00, 1, 1};
    tbl[12] = '{0, 1, 1, 'h06, 0, 1, 4, 0, 'h00, 2, 1};
    tbl[13] = '{0, 1, 0, 'h00, 0, 0, 4, 1, 'h01, 2, 1};
    tbl[14] = '{0, 1, 0, 'h00, 0, 0, 4, 1, 'h01, 2, 1};
    // Fill to full, issue A1, then push A5 in the very cycle busy is sampled.
    tbl[15] = '{1, 1, 0, 'h00, 0, 0, 0, 0, 'h00, 0, 0};
    tbl[16] = '{0, 1, 0, 'h00, 0, 1, 0, 0, 'h00, 0, 0};
    tbl[17] = '{0, 1, 1, 'hA1, 0, 1, 1, 0, 'h00, 0, 0};
    tbl[18] = '{0, 1, 0, 'h00, 0, 1, 1, 0, 'h00, 0, 0};
    tbl[19] = '{0, 1, 1, 'hA2, 0, 1, 2, 0, 'h00, 0, 0};
    tbl[20] = '{0, 1, 0, 'h00, 0, 1, 2, 0, 'h00, 0, 0};
    tbl[21] = '{0, 1, 1, 'hA3, 0, 1, 3, 0, 'h00, 0, 0};
    tbl[22] = '{0, 1, 0, 'h00, 0, 1, 3, 0, 'h00, 0, 0};
    tbl[23] = '{0, 1, 1, 'hA4, 0, 1, 4, 0, 'h00, 0, 0};
    tbl[24] = '{0, 1, 0, 'h00, 0, 0, 4, 1, 'hA1, 0, 0};
    tbl[25] = '{0, 1, 1, 'hA5, 0, 1, 4, 0, 'hA1, 0, 0};
    tbl[26] = '{0, 1, 0, 'h00, 0, 1, 4, 0, 'hA1, 0, 0};
    tbl[27] = '{0, 1, 0, 'h00, 0, 0, 4, 0, 'hA1, 0, 0};

    // Reset with Rx_VALID held high: nothing may be captured.
    @(negedge clk);
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
    @(posedge clk); #1;
    chk("rst_txdata", 32'(if0.Tx_DATA), 32'h00);
    chk("rst_wr", 32'(if0.Tx_WR), 32'h0);
    chk("rst_count", 32'(count0), 32'h0);
    chk("rst_drop", 32'(drop0), 32'h0);
    chk("rst_ovf", 32'(ovf0), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wr_seen = 0; cnt_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if0.Tx_WR) wr_seen++;
      if (count0 != 3'd0) cnt_seen++;
    end
    chk("held_valid_wr_cycles", 32'(wr_seen), 32'd0);
    chk("held_valid_count_cycles", 32'(cnt_seen), 32'd0);
    $display("reset with held Rx_VALID: wr_cycles=%0d count_cycles=%0d", wr_seen, cnt_seen);
    rx_valid = 1'b0;

    // Single byte latency.
    do_reset();
    busy_len = 3; model_on = 1'b1;
    n0 = frames0.size();
    rx_data = 8'hDA; rx_valid = 1'b1;
    @(posedge clk); #1;
    chk("lat_c1_count", 32'(count0), 32'd1);
    chk("lat_c1_wr", 32'(if0.Tx_WR), 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    chk("lat_c2_wr", 32'(if0.Tx_WR), 32'd1);
    chk("lat_c2_data", 32'(if0.Tx_DATA), 32'hDA);
    @(posedge clk); #1;
    chk("lat_c3_wr", 32'(if0.Tx_WR), 32'd1);
    @(posedge clk); #1;
    chk("lat_c4_wr", 32'(if0.Tx_WR), 32'd0);
    chk("lat_c4_count", 32'(count0), 32'd0);
    repeat (100) @(negedge clk);
    chk("single_frames", 32'(frames0.size() - n0), 32'd1);
    chk("single_frame0", f0(n0), 32'hDA);
    chk("single_count_end", 32'(count0), 32'd0);

    // Overflow fill, then drain in order.
    model_on = 1'b0;
    apply_range(0, 14);
    @(negedge clk);
    n0 = frames0.size();
    model_on = 1'b1;
    repeat (80) @(negedge clk);
    chk("ovf_frames", 32'(frames0.size() - n0), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("ovf_frame%0d", i), f0(n0 + i), 32'(i + 1));
    chk("ovf_count_end", 32'(count0), 32'd0);
    chk("ovf_drop_end", 32'(drop0), 32'd2);
    chk("ovf_sticky", 32'(ovf0), 32'd1);

    // Push into full FIFO in the pop cycle, then drain.
    model_on = 1'b0;
    apply_range(15, 27);
    @(negedge clk);
    n0 = frames0.size();
    model_on = 1'b1;
    repeat (80) @(negedge clk);
    chk("pp_frames", 32'(frames0.size() - n0), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("pp_frame%0d", i), f0(n0 + i), 32'(8'hA2 + i));
    chk("pp_count_end", 32'(count0), 32'd0);
    chk("pp_ovf", 32'(ovf0), 32'd0);
    chk("pp_drop", 32'(drop0), 32'd0);

    // Error policy: dut0 drops, dut1 substitutes ERR_BYTE.
    do_reset();
    busy_len = 2; model_on = 1'b1;
    n0 = frames0.size(); n1 = frames1.size();
    pulse(8'h55, 1'b1, 1'b0);
    repeat (30) @(negedge clk);
    chk("perr_drop_frames", 32'(frames0.size() - n0), 32'd0);
    chk("perr_drop_count", 32'(drop0), 32'd1);
    chk("perr_reply_frames", 32'(frames1.size() - n1), 32'd1);
    chk("perr_reply_byte", f1(n1), 32'h3F);
    chk("perr_reply_drop", 32'(drop1), 32'd0);
    pulse(8'h56, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("ferr_drop_count", 32'(drop0), 32'd2);
    $display("error policy: drop0=%0d reply_byte=%02h", drop0, f1(n1));
    for (int i = 0; i < 260; i++) pulse(8'(i), 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    chk("drop_saturate", 32'(drop0), 32'hFF);
    chk("drop_no_ovf", 32'(ovf0), 32'd0);
    chk("reply_ovf", 32'(ovf1), 32'd1);
    $display("saturation: drop0=%0d ovf1=%0b", drop0, ovf1);

    // en=0 while a frame is in WAIT_DONE.
    do_reset();
    model_on = 1'b0; man_busy = 1'b1;
    pulse(8'hB1, 1'b0, 1'b0);
    pulse(8'hB2, 1'b0, 1'b0);
    pulse(8'hB3, 1'b0, 1'b0);
    chk("en_queued", 32'(count0), 32'd3);
    n0 = frames0.size();
    busy_len = 8; model_on = 1'b1; man_busy = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (count0 == 3'd2 && !if0.Tx_WR) begin
        ok = 1;
        break;
      end
    end
    chk("en_reach_wait_done", 32'(ok), 32'd1);
    en = 1'b0;
    repeat (40) @(negedge clk);
    chk("en_off_frames", 32'(frames0.size() - n0), 32'd1);
    chk("en_off_frame0", f0(n0), 32'hB1);
    chk("en_off_count", 32'(count0), 32'd2);
    chk("en_off_wr", 32'(if0.Tx_WR), 32'd0);
    en = 1'b1;
    repeat (60) @(negedge clk);
    chk("en_on_frames", 32'(frames0.size() - n0), 32'd3);
    chk("en_on_frame1", f0(n0 + 1), 32'hB2);
    chk("en_on_frame2", f0(n0 + 2), 32'hB3);
    chk("en_on_count", 32'(count0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_echo_responder.md
# uart_echo_responder

- Sits between the UART receiver outputs and the UART transmitter inputs, on the same clock.
- Captures each byte the receiver validates and queues it in a small FIFO.
- Writes queued bytes back to the transmitter one frame at a time through the Tx_WR/Tx_BUSY handshake.
- Handles receive errors and overflow by policy, and exposes occupancy and error counters for the bench and for status logic.

## Interface
- FIFO_DEPTH, 4: queue entries; power of two, 2..16.
- ERR_REPLY, 0: 0 = drop bytes received with parity/framing error; 1 = enqueue ERR_BYTE in their place.
- ERR_BYTE, 8'h3F: substitute byte used when ERR_REPLY=1.

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- en  in  1  1 = accept and echo; 0 = ignore new bytes, stop issuing new frames
- Rx_DATA  in  8  received byte from receiver
- Rx_VALID  in  1  receiver valid flag, pulse or level; a byte is taken on its rising edge only
- Rx_PERROR  in  1  parity error for current Rx_DATA
- Rx_FERROR  in  1  framing error for current Rx_DATA
- Tx_BUSY  in  1  transmitter busy with a frame
- Tx_DATA  out  8  byte presented to transmitter
- Tx_WR  out  1  write request, level, held until Tx_BUSY seen
- fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy
- drop_count  out  8  bytes lost to errors (ERR_REPLY=0) or overflow; saturates at 255
- overflow  out  1  sticky; set on any write attempt while full

## Operation

**Capture**
- rise = Rx_VALID & ~valid_q, where valid_q is Rx_VALID registered.
- valid_q resets to 1, so Rx_VALID held high across reset is not captured.
- On rise with en=1:
  - No error: push Rx_DATA.
  - Error (PERROR|FERROR) with ERR_REPLY=0: drop the byte, drop_count+1.
  - Error with ERR_REPLY=1: push ERR_BYTE.
- rise with en=0 is ignored and not counted.

**FIFO**
- Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
- Push and pop in the same cycle are both performed, including when full (the pop frees the slot); count is unchanged.
- Push while full without a pop: byte discarded, overflow=1, drop_count+1.

**Transmit FSM, states IDLE, ISSUE, WAIT_DONE**
- IDLE:
  - Tx_WR=0.
  - If en=1, FIFO not empty, and Tx_BUSY=0: load Tx_DATA from the FIFO head, go to ISSUE.
- ISSUE:
  - Tx_WR=1.
  - When Tx_BUSY=1 is sampled: pop the FIFO and go to WAIT_DONE; Tx_WR drops the next cycle.
  - Waits indefinitely; en=0 does not abort ISSUE.
- WAIT_DONE:
  - Tx_WR=0.
  - When Tx_BUSY=0: go to IDLE.
- Tx_DATA stays stable from entry to ISSUE until the next IDLE→ISSUE load.
- en=0 during WAIT_DONE: the current frame completes, then the FSM stays in IDLE with the FIFO contents retained.

## Timing
- Reset values:
  - Tx_DATA=0, Tx_WR=0, fifo_count=0, drop_count=0, overflow=0.
  - FSM=IDLE, pointers=0, valid_q=1.
- Reset mid-frame: FSM returns to IDLE and the FIFO is flushed next edge; the transmitter is not signalled.
- Latency: let cycle 0 be the first cycle with Rx_VALID=1 sampled.
  - Push occurs at the end of cycle 0.
  - fifo_count=1 in cycle 1.
  - Tx_WR=1 and Tx_DATA valid in cycle 2 (FIFO was empty, Tx_BUSY=0).
- Tx_BUSY rising in cycle k while in ISSUE:
  - Pop happens at the end of cycle k.
  - Tx_WR=0 from cycle k+1.
- Back-to-back frames: minimum 2 cycles from Tx_BUSY falling to next Tx_WR rising (WAIT_DONE→IDLE, IDLE→ISSUE).
- Counters:
  - drop_count is 8-bit and saturates at 8'hFF; no wrap.
  - fifo_count never exceeds FIFO_DEPTH.

## Test plan
- Reset with Rx_VALID held 1, release, hold 20 cycles -> fifo_count=0, Tx_WR=0, no capture.
- Single byte 8'hDA, transmitter model asserts Tx_BUSY 1 cycle after Tx_WR for 100 cycles -> Tx_WR high from cycle 2, Tx_DATA=8'hDA, one frame issued, fifo_count returns to 0.
- Six bytes 8'h01..8'h06 while Tx_BUSY held 1 (FIFO_DEPTH=4) -> fifo_count=4, overflow=1, drop_count=2; after release, frames 01,02,03,04 in order.
- Byte 8'h55 with Rx_PERROR=1: ERR_REPLY=0 -> no frame, drop_count=1; ERR_REPLY=1 -> frame with Tx_DATA=8'h3F.
- Push with FIFO full in the same cycle Tx_BUSY rises in ISSUE -> count stays 4, overflow stays 0, new byte later sent in order.
- en=0 during WAIT_DONE with 2 bytes queued -> current frame finishes, no new Tx_WR, fifo_count=2; en=1 -> both drained.
